// File: rtl/pio_regbus_arbiter.sv
// Two-port req/gnt/done arbiter sharing the PIO control register file's single access port.
// Optional address range/alignment checking is compiled in with `define PIO_REGBUS_ADDR_CHECK_EN.
module pio_regbus_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req,
  input  logic [1:0]             we,
  input  logic [1:0][ADDR_W-1:0] addr,
  input  logic [1:0][DATA_W-1:0] wdata,
  output logic [1:0]             gnt,
  output logic [1:0]             done,
  output logic [DATA_W-1:0]      rdata,
  output logic [1:0]             err,
  output logic [ADDR_W-1:0]      rf_write_addr,
  output logic [DATA_W-1:0]      rf_data_in,
  output logic                   rf_write_en,
  output logic [ADDR_W-1:0]      rf_read_addr,
  input  logic [DATA_W-1:0]      rf_data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state;
  logic   last_ptr;
  logic   cur_we;
  logic   cur_bad;
  logic   winner;
  logic   win_bad;

  // On a tie the port that was not granted last wins, unless port 0 is pinned as the winner.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b10) begin
      winner = 1'b1;
    end else if (req == 2'b11) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_ptr;
    end
  end

`ifdef PIO_REGBUS_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(9'h140);
  assign win_bad = (addr[winner][1:0] != 2'b00) || (addr[winner] > ADDR_MAX);
`else
  assign win_bad = 1'b0;
`endif

  always_comb begin
    gnt = 2'b00;
    if (rst_n && (state == IDLE) && (req != 2'b00)) begin
      gnt[winner] = 1'b1;
    end
  end

  // last_ptr doubles as the owner of the in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_ptr      <= 1'b1;
      cur_we        <= 1'b0;
      cur_bad       <= 1'b0;
      done          <= 2'b00;
      err           <= 2'b00;
      rdata         <= '0;
      rf_write_addr <= '0;
      rf_data_in    <= '0;
      rf_write_en   <= 1'b0;
      rf_read_addr  <= '0;
    end else begin
      done        <= 2'b00;
      err         <= 2'b00;
      rf_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            last_ptr      <= winner;
            cur_we        <= we[winner];
            cur_bad       <= win_bad;
            rf_write_addr <= addr[winner];
            rf_data_in    <= wdata[winner];
            if (!win_bad) begin
              rf_read_addr <= addr[winner];
            end
            rf_write_en   <= we[winner] & ~win_bad;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          rdata          <= (cur_we || cur_bad) ? '0 : rf_data_out;
          done[last_ptr] <= 1'b1;
          err[last_ptr]  <= cur_bad;
          state          <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_regbus_arbiter.sv
// Self-checking bench for pio_regbus_arbiter: transaction-level reference model plus directed cases.
// A second instance with FIXED_PRIO=1 sees both ports requesting continuously.
module tb_pio_regbus_arbiter;

  localparam int FP = 0;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0][8:0]  addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [31:0]      rdata;
  logic [1:0]       err;
  logic [8:0]       rf_write_addr;
  logic [31:0]      rf_data_in;
  logic             rf_write_en;
  logic [8:0]       rf_read_addr;
  logic [31:0]      rf_data_out;

  logic [1:0]       req_fp;
  logic [1:0]       we_fp;
  logic [1:0][8:0]  addr_fp;
  logic [1:0][31:0] wdata_fp;
  logic [1:0]       gnt_fp;
  logic [1:0]       done_fp;
  logic [31:0]      rdata_fp;
  logic [1:0]       err_fp;
  logic [8:0]       rf_write_addr_fp;
  logic [31:0]      rf_data_in_fp;
  logic             rf_write_en_fp;
  logic [8:0]       rf_read_addr_fp;
  logic [31:0]      rf_data_out_fp;

  int checks;
  int failures;

  pio_regbus_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRIO(FP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .rf_write_addr(rf_write_addr), .rf_data_in(rf_data_in), .rf_write_en(rf_write_en),
    .rf_read_addr(rf_read_addr), .rf_data_out(rf_data_out)
  );

  pio_regbus_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req_fp), .we(we_fp), .addr(addr_fp), .wdata(wdata_fp),
    .gnt(gnt_fp), .done(done_fp), .rdata(rdata_fp), .err(err_fp),
    .rf_write_addr(rf_write_addr_fp), .rf_data_in(rf_data_in_fp), .rf_write_en(rf_write_en_fp),
    .rf_read_addr(rf_read_addr_fp), .rf_data_out(rf_data_out_fp)
  );

  assign req_fp         = 2'b11;
  assign we_fp          = 2'b00;
  assign addr_fp        = '0;
  assign wdata_fp       = '0;
  assign rf_data_out_fp = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model seen by the DUT: combinational read, write on the clock edge.
  logic [31:0] rf_mem [512];
  assign rf_data_out = rf_mem[rf_read_addr];

  initial begin
    for (int i = 0; i < 512; i++) rf_mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    rf_mem[9'h0C8] = 32'h0001_0000;
    forever begin
      @(posedge clk);
      if (rf_write_en) rf_mem[rf_write_addr] = rf_data_in;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [8:0] rand_addr();
    logic [8:0] a;
    if ($urandom_range(0, 3) == 0) a = 9'($urandom_range(0, 511));
    else a = {7'($urandom_range(0, 80)), 2'b00};
    return a;
  endfunction

  function automatic bit addr_bad(input logic [8:0] a);
`ifdef PIO_REGBUS_ADDR_CHECK_EN
    return (a % 4 != 0) || (a > 9'h140);
`else
    return (a != a);
`endif
  endfunction

  // Reference model: one transaction record, timed by cycle numbers relative to its grant.
  int          cyc;
  bit          model_ready;
  bit          have_tx;
  int          tx_t;
  int          tx_port;
  bit          tx_we;
  bit          tx_bad;
  logic [8:0]  tx_addr;
  logic [31:0] tx_wdata;
  bit          m_last;
  logic [8:0]  m_wa;
  logic [8:0]  m_ra;
  logic [31:0] m_din;
  logic [31:0] m_rdata;
  logic [1:0]  m_eg;
  logic [1:0]  m_ed;
  logic [1:0]  m_ee;
  logic        m_ewe;
  int          m_w;
  logic [31:0] model_mem [512];

  always @(negedge clk) begin
    if (!model_ready) begin
      for (int i = 0; i < 512; i++) model_mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
      model_mem[9'h0C8] = 32'h0001_0000;
      model_ready = 1'b1;
    end
    m_eg = 2'b00; m_ed = 2'b00; m_ee = 2'b00; m_ewe = 1'b0;
    if (!rst_n) begin
      have_tx = 1'b0; m_last = 1'b1;
      m_wa = '0; m_ra = '0; m_din = '0; m_rdata = '0;
    end else if (have_tx) begin
      if (cyc == tx_t + 1) begin
        m_ewe = tx_we && !tx_bad;
        if (m_ewe) model_mem[tx_addr] = tx_wdata;
      end
      if (cyc == tx_t + 2) begin
        m_ed[tx_port] = 1'b1;
        m_ee[tx_port] = tx_bad;
        m_rdata = (tx_we || tx_bad) ? 32'h0 : model_mem[tx_addr];
      end
    end
    checkOutput("rf_write_en", rf_write_en, m_ewe);
    checkOutput("done", done, m_ed);
    checkOutput("err", err, m_ee);
    checkOutput("rdata", rdata, m_rdata);
    checkOutput("rf_write_addr", rf_write_addr, m_wa);
    checkOutput("rf_data_in", rf_data_in, m_din);
    checkOutput("rf_read_addr", rf_read_addr, m_ra);
    if (rst_n && (!have_tx || cyc >= tx_t + 3) && req != 2'b00) begin
      if (req == 2'b11) m_w = (FP != 0) ? 0 : (m_last ? 0 : 1);
      else m_w = req[1] ? 1 : 0;
      m_eg[m_w] = 1'b1;
      m_last   = (m_w == 1);
      have_tx  = 1'b1;
      tx_t     = cyc;
      tx_port  = m_w;
      tx_we    = we[m_w];
      tx_addr  = addr[m_w];
      tx_wdata = wdata[m_w];
      tx_bad   = addr_bad(addr[m_w]);
      m_wa     = tx_addr;
      m_din    = tx_wdata;
      if (!tx_bad) m_ra = tx_addr;
    end
    checkOutput("gnt", gnt, m_eg);
    cyc++;
  end

  // Fixed-priority instance: port 0 granted every third cycle after reset, port 1 never.
  int fp_cyc;
  always @(negedge clk) begin
    if (!rst_n) begin
      fp_cyc = 0;
    end else begin
      checkOutput("fp_gnt", gnt_fp, (fp_cyc % 3 == 0) ? 2'b01 : 2'b00);
      checkOutput("fp_done", done_fp, (fp_cyc % 3 == 2) ? 2'b01 : 2'b00);
      fp_cyc++;
    end
  end

  // Issues one transaction on one port, holding it until granted; returns just after the grant edge.
  task automatic applyStimulus(input int p, input logic w, input logic [8:0] a,
                               input logic [31:0] d, output bit ok);
    @(posedge clk); #1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (gnt[p]) ok = 1'b1;
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
    if (!ok) checkOutput("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic randomTraffic(input int ncyc);
    logic [1:0] g;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (g[p]) req[p] = 1'b0;
        if (!req[p] && $urandom_range(0, 1) == 1) begin
          req[p]   = 1'b1;
          we[p]    = 1'($urandom_range(0, 1));
          addr[p]  = rand_addr();
          wdata[p] = $urandom;
        end
      end
    end
  endtask

  logic [1:0] rr_g [12];
  logic [1:0] rr_d [12];
  bit         ok;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; model_ready = 1'b0;
    rr_g = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    rr_d = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_gnt", gnt, 2'b00);
    checkOutput("reset_rf_write_en", rf_write_en, 1'b0);
    rst_n = 1'b1;
    req = 2'b11; addr[0] = 9'h010; addr[1] = 9'h020;

    // Both ports requesting continuously from reset: alternate grants, done two cycles later.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_gnt_%0d", k), gnt, rr_g[k]);
      checkOutput($sformatf("rr_done_%0d", k), done, rr_d[k]);
    end
    @(posedge clk); #1;
    req = 2'b00;

    applyStimulus(0, 1'b1, 9'h038, 32'hDEADBEEF, ok);
    @(negedge clk);
    checkOutput("wr_we_t1", rf_write_en, 1'b1);
    checkOutput("wr_addr_t1", rf_write_addr, 9'h038);
    checkOutput("wr_data_t1", rf_data_in, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("wr_done_t2", done, 2'b01);
    checkOutput("wr_rdata_t2", rdata, 32'h0);
    checkOutput("wr_we_t2", rf_write_en, 1'b0);

    applyStimulus(1, 1'b0, 9'h0C8, 32'h0, ok);
    @(negedge clk);
    checkOutput("rd_addr_t1", rf_read_addr, 9'h0C8);
    checkOutput("rd_we_t1", rf_write_en, 1'b0);
    @(negedge clk);
    checkOutput("rd_done_t2", done, 2'b10);
    checkOutput("rd_rdata_t2", rdata, 32'h0001_0000);

    // Reset lands during the ISSUE cycle of a write.
    applyStimulus(0, 1'b1, 9'h044, 32'h1234_5678, ok);
    #1;
    checkOutput("rst_we_before", rf_write_en, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_we_drop", rf_write_en, 1'b0);
    checkOutput("rst_done", done, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 2'b11; we = 2'b00;
    @(negedge clk);
    checkOutput("rst_tie_port0", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    repeat (3) @(posedge clk);

`ifdef PIO_REGBUS_ADDR_CHECK_EN
    applyStimulus(0, 1'b1, 9'h142, 32'h1111_1111, ok);
    @(negedge clk);
    checkOutput("chk142_we", rf_write_en, 1'b0);
    @(negedge clk);
    checkOutput("chk142_done", done, 2'b01);
    checkOutput("chk142_err", err, 2'b01);
    applyStimulus(0, 1'b1, 9'h039, 32'h2222_2222, ok);
    @(negedge clk);
    checkOutput("chk039_we", rf_write_en, 1'b0);
    @(negedge clk);
    checkOutput("chk039_err", err, 2'b01);
    applyStimulus(0, 1'b1, 9'h140, 32'h3333_3333, ok);
    @(negedge clk);
    checkOutput("chk140_we", rf_write_en, 1'b1);
    @(negedge clk);
    checkOutput("chk140_err", err, 2'b00);
    checkOutput("chk140_done", done, 2'b01);
`endif

    randomTraffic(1500);
    @(posedge clk); #1;
    req = 2'b00;
    repeat (6) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
